// File: rtl/alu_ctrl_mc.sv
`default_nettype none
// ============================================================================
// Module   : alu_ctrl_mc
// Purpose  : EX-stage ALU controller. Decodes ALUOp/funct to an ALU op code,
//            flags jr and undefined encodings, and sequences an iterative
//            multiplier by stalling the pipeline and gating write-back until
//            the product is ready.
// Ports    : clk_i          - clock, rising edge
//            rst_i          - synchronous active-high reset
//            valid_i        - an instruction occupies EX this cycle
//            funct_i[5:0]   - R-type funct field
//            ALUOp_i[2:0]   - ALUOp from the main decoder
//            flush_i        - abort any in-flight multi-cycle op
//            ALUCtrl_o      - ALU op code (CTRL_W bits, codes in low 4 bits)
//            IndirectJump_o - jr in EX: PC <- rs
//            stall_o        - freeze PC/IF/ID/EX registers this cycle
//            wb_en_o        - ALU result may be written back this cycle
//            illegal_o      - undefined encoding while valid_i
// Revision : 1.0 - initial release
// ============================================================================
module alu_ctrl_mc #(
  parameter int CTRL_W     = 4,
  parameter int MUL_CYCLES = 4,
  parameter int ENABLE_MUL = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic [5:0]        funct_i,
  input  logic [2:0]        ALUOp_i,
  input  logic              flush_i,
  output logic [CTRL_W-1:0] ALUCtrl_o,
  output logic              IndirectJump_o,
  output logic              stall_o,
  output logic              wb_en_o,
  output logic              illegal_o
);

  localparam int CW = $clog2(MUL_CYCLES) + 1;
  // First BUSY cycle already counts toward the latency, hence the -2.
  localparam logic [CW-1:0] C_CNT_INIT = (MUL_CYCLES > 1) ? CW'(MUL_CYCLES - 2) : '0;
  localparam logic [CW-1:0] C_CNT_ONE  = CW'(1);
  localparam logic [3:0]    C_OP_MUL   = 4'b0011;
  localparam bit            C_MULTI    = (MUL_CYCLES > 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CTRL_W-1:0] op_q, op_d;

  // Combinational decode results
  logic [3:0] w_code;
  logic       w_legal;
  logic       w_jr;
  logic       w_mul;

  always_comb begin
    w_code  = 4'b0000;
    w_legal = 1'b0;
    w_jr    = 1'b0;
    w_mul   = 1'b0;
    case (ALUOp_i)
      3'b000: begin w_code = 4'b0010; w_legal = 1'b1; end
      3'b001: begin w_code = 4'b0110; w_legal = 1'b1; end
      3'b011: begin w_code = 4'b0001; w_legal = 1'b1; end
      3'b100: begin w_code = 4'b0111; w_legal = 1'b1; end
      3'b101: begin w_code = 4'b0000; w_legal = 1'b1; end
      3'b010: begin
        case (funct_i)
          6'b100000: begin w_code = 4'b0010; w_legal = 1'b1; end
          6'b100010: begin w_code = 4'b0110; w_legal = 1'b1; end
          6'b100100: begin w_code = 4'b0000; w_legal = 1'b1; end
          6'b100101: begin w_code = 4'b0001; w_legal = 1'b1; end
          6'b101010: begin w_code = 4'b0111; w_legal = 1'b1; end
          6'b000000: begin w_code = 4'b1000; w_legal = 1'b1; end
          6'b000100: begin w_code = 4'b1010; w_legal = 1'b1; end
          6'b000010: begin w_code = 4'b1001; w_legal = 1'b1; end
          6'b000110: begin w_code = 4'b1011; w_legal = 1'b1; end
          6'b001000: begin w_code = 4'b0010; w_legal = 1'b1; w_jr = 1'b1; end
          6'b011000: begin
            if (ENABLE_MUL != 0) begin
              w_code  = C_OP_MUL;
              w_legal = 1'b1;
              w_mul   = 1'b1;
            end
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // Next-state and outputs
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    op_d           = op_q;
    ALUCtrl_o      = '0;
    IndirectJump_o = 1'b0;
    stall_o        = 1'b0;
    wb_en_o        = 1'b0;
    illegal_o      = 1'b0;

    if (rst_i) begin
      // Outputs held at zero; the register block applies the reset values.
    end else if (state_q == S_IDLE) begin
      ALUCtrl_o      = w_legal ? CTRL_W'(w_code) : '0;
      illegal_o      = valid_i & ~w_legal;
      IndirectJump_o = valid_i & w_jr;
      if (valid_i && w_mul && C_MULTI && !flush_i) begin
        stall_o = 1'b1;
        op_d    = CTRL_W'(w_code);
        cnt_d   = C_CNT_INIT;
        state_d = S_BUSY;
      end else begin
        // A MUL with MUL_CYCLES==1 falls through here as a single-cycle op.
        wb_en_o = valid_i & w_legal & ~w_jr & ~flush_i & ~(w_mul & C_MULTI);
      end
    end else begin
      ALUCtrl_o = op_q;
      if (flush_i) begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end else if (cnt_q != '0) begin
        stall_o = 1'b1;
        cnt_d   = cnt_q - C_CNT_ONE;
      end else begin
        wb_en_o = 1'b1;
        state_d = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

endmodule
`default_nettype wire
